// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving the select/enable of a 3:8 decoder.
// Steps sel through 0..7, holding each index for a latched dwell time,
// either once (one-shot, ends with a done pulse) or continuously.
module decoder_scan_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               step,
  output logic               done
);

  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(7);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   sel_n;
  logic               sel_en_n;
  logic               busy_n;
  logic               step_n;
  logic               done_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic               mode_q, mode_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [DWELL_W-1:0] d_start_c;

  // Effective dwell at start: a zero request is treated as a single cycle.
  assign d_start_c = (dwell == '0) ? DWELL_ONE : dwell;

  // State, output and latched-configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= SEL_FIRST;
      sel_en  <= 1'b0;
      busy    <= 1'b0;
      step    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      mode_q  <= 1'b0;
      dwell_q <= DWELL_ONE;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      sel_en  <= sel_en_n;
      busy    <= busy_n;
      step    <= step_n;
      done    <= done_n;
      cnt     <= cnt_n;
      mode_q  <= mode_n;
      dwell_q <= dwell_n;
    end
  end

  // Next-state and next-output logic; step/done default low so they pulse.
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    sel_en_n = sel_en;
    busy_n   = busy;
    step_n   = 1'b0;
    done_n   = 1'b0;
    cnt_n    = cnt;
    mode_n   = mode_q;
    dwell_n  = dwell_q;

    unique case (state)
      IDLE: begin
        sel_n    = SEL_FIRST;
        sel_en_n = 1'b0;
        busy_n   = 1'b0;
        // stop has priority over a simultaneous start
        if (start && !stop) begin
          state_n  = RUN;
          sel_en_n = 1'b1;
          busy_n   = 1'b1;
          step_n   = 1'b1;
          cnt_n    = d_start_c - DWELL_ONE;
          mode_n   = mode;
          dwell_n  = d_start_c;
        end
      end

      RUN: begin
        if (stop) begin
          // abort: a partial scan never reports done
          state_n  = IDLE;
          sel_n    = SEL_FIRST;
          sel_en_n = 1'b0;
          busy_n   = 1'b0;
        end else if (cnt != '0) begin
          cnt_n = cnt - DWELL_ONE;
        end else if (sel != SEL_LAST) begin
          sel_n  = SEL_W'(sel + SEL_W'(1));
          cnt_n  = dwell_q - DWELL_ONE;
          step_n = 1'b1;
        end else if (mode_q) begin
          sel_n  = SEL_FIRST;
          cnt_n  = dwell_q - DWELL_ONE;
          step_n = 1'b1;
        end else begin
          state_n  = IDLE;
          sel_n    = SEL_FIRST;
          sel_en_n = 1'b0;
          busy_n   = 1'b0;
          done_n   = 1'b1;
        end
      end

      default: begin
        state_n  = IDLE;
        sel_n    = SEL_FIRST;
        sel_en_n = 1'b0;
        busy_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed, table-driven bench for decoder_scan_sequencer.
module tb_decoder_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_en;
  logic       busy;
  logic       step;
  logic       done;

  int errors = 0;
  int checks = 0;

  decoder_scan_sequencer #(.DWELL_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .dwell  (dwell),
    .sel    (sel),
    .sel_en (sel_en),
    .busy   (busy),
    .step   (step),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one vector: inputs sampled at an edge, outputs expected just after it
  typedef struct {
    string      tag;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_en;
    logic       busy;
    logic       step;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string tag, logic st, logic sp, logic md, logic [7:0] dw,
                              logic [2:0] s, logic en, logic bz, logic stp, logic dn);
    vec_t v;
    v.tag = tag; v.start = st; v.stop = sp; v.mode = md; v.dwell = dw;
    v.sel = s; v.sel_en = en; v.busy = bz; v.step = stp; v.done = dn;
    vecs.push_back(v);
  endfunction

  // complete one-shot scan of effective dwell d, requested with dwell input dw
  function automatic void add_oneshot(string tag, logic [7:0] dw, int d);
    for (int c = 1; c <= 8 * d; c++)
      add(tag, c == 1, 1'b0, 1'b0, dw, 3'((c - 1) / d), 1'b1, 1'b1, ((c - 1) % d) == 0, 1'b0);
    add(tag, 1'b0, 1'b0, 1'b0, dw, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(tag, 1'b0, 1'b0, 1'b0, dw, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [6:0] pack(logic [2:0] s, logic en, logic bz, logic stp, logic dn);
    return {s, en, bz, stp, dn};
  endfunction

  task automatic check(string name, logic [6:0] exp);
    logic [6:0] act;
    act = {sel, sel_en, busy, step, done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: {sel,en,busy,step,done} got %b_%b%b%b%b expected %b_%b%b%b%b",
               name, $time, act[6:4], act[3], act[2], act[1], act[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(logic st, logic sp, logic md, logic [7:0] dw);
    @(negedge clk);
    start = st; stop = sp; mode = md; dwell = dw;
    @(posedge clk);
    #1;
  endtask

  // done and busy must never coincide
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (done && busy) begin
        errors++;
        $display("FAIL done_busy_excl t=%0t: done=%b busy=%b expected not both", $time, done, busy);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; dwell = 8'd0;

    // one-shot scans: dwell 1, dwell 0 (same as 1), dwell 3 (done at cycle 25)
    add_oneshot("os_d1", 8'd1, 1);
    add_oneshot("os_d0", 8'd0, 1);
    add_oneshot("os_d3", 8'd3, 3);

    // continuous dwell 2: wrap at cycle 17, stop while sel=4 on second pass
    for (int c = 1; c <= 25; c++)
      add("cont_d2", c == 1, 1'b0, 1'b1, 8'd2, 3'(((c - 1) / 2) % 8), 1'b1, 1'b1, ((c - 1) % 2) == 0, 1'b0);
    add("cont_stop", 1'b0, 1'b1, 1'b1, 8'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("after_stop", 1'b0, 1'b0, 1'b1, 8'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // one-shot dwell 2 with a start (and mode=1) pulse at sel=3 and dwell changed to 5
    for (int c = 1; c <= 16; c++)
      add("ignore_start", (c == 1) || (c == 8), 1'b0, c == 8, (c >= 3) ? 8'd5 : 8'd2,
          3'((c - 1) / 2), 1'b1, 1'b1, ((c - 1) % 2) == 0, 1'b0);
    add("ignore_done", 1'b0, 1'b0, 1'b0, 8'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("ignore_idle", 1'b0, 1'b0, 1'b0, 8'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start+stop in IDLE: stop wins; then stop alone in IDLE
    add("start_stop_idle", 1'b1, 1'b1, 1'b0, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("stay_idle", 1'b0, 1'b1, 1'b0, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("stay_idle2", 1'b0, 1'b0, 1'b0, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset with inputs toggling
    #1;
    check("reset_t0", pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom); stop = 1'($urandom); mode = 1'($urandom); dwell = 8'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; mode = 1'b0; dwell = 8'd1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd1);
      check("idle_no_start", pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // table
    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].dwell);
      check(vecs[i].tag, pack(vecs[i].sel, vecs[i].sel_en, vecs[i].busy, vecs[i].step, vecs[i].done));
    end

    // maximum dwell: index 0 held exactly 255 cycles
    drive(1'b1, 1'b0, 1'b0, 8'd255);
    check("dmax_first", pack(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    for (int c = 2; c <= 255; c++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd255);
      check("dmax_hold0", pack(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    end
    drive(1'b0, 1'b0, 1'b0, 8'd255);
    check("dmax_sel1", pack(3'd1, 1'b1, 1'b1, 1'b1, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 8'd255);
    check("dmax_stop", pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // asynchronous reset between edges while sel=5
    drive(1'b1, 1'b0, 1'b0, 8'd1);
    for (int k = 1; k <= 5; k++) drive(1'b0, 1'b0, 1'b0, 8'd1);
    check("pre_async_sel5", pack(3'd5, 1'b1, 1'b1, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd1);
    check("post_reset_idle", pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 8'd1);
    check("restart_sel0", pack(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 8'd1);
    check("restart_sel1", pack(3'd1, 1'b1, 1'b1, 1'b1, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
